// File: rtl/clkgen_div_n_pkg.sv
// Shared definitions for the clkgen_div_n clock-divider / enable generator.
// Holds default geometry and the control-priority decode used by every register group.
package clkgen_div_n_pkg;

    localparam int DEF_NUM_DIV = 3;
    localparam int DEF_HP_W    = 8;

    typedef enum logic [1:0] {
        ACT_RESET = 2'd0,
        ACT_SYNC  = 2'd1,
        ACT_RUN   = 2'd2,
        ACT_HOLD  = 2'd3
    } ctrl_act_e;

    // Reset beats sync, sync beats enable; both divider paths must agree on this order.
    function automatic ctrl_act_e decode_ctrl(input logic reset_L,
                                              input logic sync,
                                              input logic en);
        if (!reset_L) begin
            return ACT_RESET;
        end else if (sync) begin
            return ACT_SYNC;
        end else if (en) begin
            return ACT_RUN;
        end
        return ACT_HOLD;
    endfunction

endpackage

// File: rtl/clkgen_div_n_if.sv
// Control and output bundle of clkgen_div_n; the master side drives en/sync/div_half
// and observes the divided clocks, strobes and lock indication.
interface clkgen_div_n_if #(
    parameter int NUM_DIV = 3,
    parameter int HP_W    = 8
);
    logic               en;
    logic               sync;
    logic [HP_W-1:0]    div_half;
    logic [NUM_DIV-1:0] clk_div;
    logic [NUM_DIV-1:0] rise_stb;
    logic               clk_prog;
    logic               prog_stb;
    logic               locked;

    modport master (
        output en, sync, div_half,
        input  clk_div, rise_stb, clk_prog, prog_stb, locked
    );

    modport slave (
        input  en, sync, div_half,
        output clk_div, rise_stb, clk_prog, prog_stb, locked
    );
endinterface

// File: rtl/clkgen_div_n_prog_div.sv
// Programmable half-period divider: clk_prog toggles every max(shadow,1) enabled cycles.
// div_half is captured into shadow only at a toggle, so a running half-period always completes.
module clkgen_prog_div
    import clkgen_div_n_pkg::*;
#(
    parameter int HP_W = DEF_HP_W
) (
    input  logic            clk,
    input  logic            reset_L,
    input  logic            en,
    input  logic            sync,
    input  logic [HP_W-1:0] div_half,
    output logic            clk_prog,
    output logic            prog_stb
);

    logic [HP_W-1:0] hp_cnt;
    logic [HP_W-1:0] shadow;
    logic [HP_W-1:0] eff;
    logic [HP_W-1:0] limit;
    logic            wrap;
    ctrl_act_e       act;

    // >= rather than == keeps a shrunken half-period from running past its limit.
    always_comb begin
        act   = decode_ctrl(reset_L, sync, en);
        eff   = (shadow == '0) ? HP_W'(1) : shadow;
        limit = eff - HP_W'(1);
        wrap  = (hp_cnt >= limit);
    end

    always_ff @(posedge clk) begin
        unique case (act)
            ACT_RESET, ACT_SYNC: begin
                hp_cnt   <= '0;
                shadow   <= div_half;
                clk_prog <= 1'b0;
                prog_stb <= 1'b0;
            end
            ACT_RUN: begin
                if (wrap) begin
                    hp_cnt   <= '0;
                    shadow   <= div_half;
                    clk_prog <= ~clk_prog;
                    prog_stb <= ~clk_prog;
                end else begin
                    hp_cnt   <= hp_cnt + HP_W'(1);
                    prog_stb <= 1'b0;
                end
            end
            default: begin
                prog_stb <= 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        assert (!prog_stb || clk_prog);
    end

endmodule

// File: rtl/clkgen_div_n.sv
// Fully synchronous clock-divider / enable generator: binary divided clocks straight from
// one free-running counter, per-bit rising strobes, lock indication and a programmable divider.
module clkgen_div_n
    import clkgen_div_n_pkg::*;
#(
    parameter int NUM_DIV = DEF_NUM_DIV,
    parameter int HP_W    = DEF_HP_W
) (
    input  logic          clk,
    input  logic          reset_L,
    clkgen_div_n_if.slave bus
);

    localparam logic [NUM_DIV-1:0] CNT_MAX = '1;

    logic [NUM_DIV-1:0] cnt;
    logic [NUM_DIV-1:0] cnt_next;
    logic [NUM_DIV-1:0] rise_stb;
    logic               locked;
    logic               clk_prog;
    logic               prog_stb;
    ctrl_act_e          act;

    always_comb begin
        act      = decode_ctrl(reset_L, bus.sync, bus.en);
        cnt_next = cnt + NUM_DIV'(1);
    end

    // The counter bits are the divided clocks, so each output is a flop with no decode glitch.
    always_ff @(posedge clk) begin
        unique case (act)
            ACT_RESET, ACT_SYNC: begin
                cnt      <= '0;
                rise_stb <= '0;
                locked   <= 1'b0;
            end
            ACT_RUN: begin
                cnt      <= cnt_next;
                rise_stb <= cnt_next & ~cnt;
                if (cnt == CNT_MAX) begin
                    locked <= 1'b1;
                end
            end
            default: begin
                rise_stb <= '0;
            end
        endcase
    end

    clkgen_prog_div #(
        .HP_W(HP_W)
    ) u_prog_div (
        .clk      (clk),
        .reset_L  (reset_L),
        .en       (bus.en),
        .sync     (bus.sync),
        .div_half (bus.div_half),
        .clk_prog (clk_prog),
        .prog_stb (prog_stb)
    );

    assign bus.clk_div  = cnt;
    assign bus.rise_stb = rise_stb;
    assign bus.locked   = locked;
    assign bus.clk_prog = clk_prog;
    assign bus.prog_stb = prog_stb;

    always_ff @(posedge clk) begin
        assert ((rise_stb & ~cnt) == '0);
    end

endmodule
